// File: rtl/tri_setup_ctrl.sv
// Triangle setup sequencer: requests the three edge equations from an external
// edge unit over a valid handshake, then reduces the c terms into a signed area.
`timescale 1ns/1ps
module tri_setup_ctrl #(
    parameter int W  = 18,
    parameter int AW = 20
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      x0,
    input  logic [9:0]      y0,
    input  logic [9:0]      x1,
    input  logic [9:0]      y1,
    input  logic [9:0]      x2,
    input  logic [9:0]      y2,
    output logic            busy,
    output logic            done,
    output logic [3*W-1:0]  eq0,
    output logic [3*W-1:0]  eq1,
    output logic [3*W-1:0]  eq2,
    output logic [AW-1:0]   area,
    output logic            degenerate,
    output logic            backface,
    output logic            ee_trigger,
    output logic [9:0]      ee_x1,
    output logic [9:0]      ee_y1,
    output logic [9:0]      ee_x2,
    output logic [9:0]      ee_y2,
    input  logic            ee_valid,
    input  logic [W-1:0]    ee_a,
    input  logic [W-1:0]    ee_b,
    input  logic [W-1:0]    ee_c
);
    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | edge k coordinates presented, trigger when the unit is ready
    // SETTLE | one cycle for the unit to drop ee_valid after the trigger
    // WAIT   | waiting for the edge k result
    // FINISH | all three edges captured, register the area sum
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, FINISH} state_t;

    state_t state, state_nxt;
    logic [1:0] k;
    logic [9:0] lx0, ly0, lx1, ly1, lx2, ly2;
    logic signed [AW-1:0] c0_ext, c1_ext, c2_ext, area_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (ee_valid) state_nxt = SETTLE;
            SETTLE:  state_nxt = WAIT;
            WAIT:    if (ee_valid) state_nxt = (k == 2'd2) ? FINISH : ISSUE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        ee_trigger = (state == ISSUE) && ee_valid;
        ee_x1 = lx0;
        ee_y1 = ly0;
        ee_x2 = lx1;
        ee_y2 = ly1;
        case (k)
            2'd1: begin
                ee_x1 = lx1; ee_y1 = ly1; ee_x2 = lx2; ee_y2 = ly2;
            end
            2'd2: begin
                ee_x1 = lx2; ee_y1 = ly2; ee_x2 = lx0; ee_y2 = ly0;
            end
            default: ;
        endcase
    end

    // c sits in the low W bits of each packed {a,b,c}
    assign c0_ext   = AW'($signed(eq0[W-1:0]));
    assign c1_ext   = AW'($signed(eq1[W-1:0]));
    assign c2_ext   = AW'($signed(eq2[W-1:0]));
    assign area_sum = c0_ext + c1_ext + c2_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k          <= 2'd0;
            lx0        <= '0;
            ly0        <= '0;
            lx1        <= '0;
            ly1        <= '0;
            lx2        <= '0;
            ly2        <= '0;
            eq0        <= '0;
            eq1        <= '0;
            eq2        <= '0;
            area       <= '0;
            degenerate <= 1'b0;
            backface   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (state == IDLE && start) begin
                k   <= 2'd0;
                lx0 <= x0;
                ly0 <= y0;
                lx1 <= x1;
                ly1 <= y1;
                lx2 <= x2;
                ly2 <= y2;
            end
            if (state == WAIT && ee_valid) begin
                case (k)
                    2'd0:    eq0 <= {ee_a, ee_b, ee_c};
                    2'd1:    eq1 <= {ee_a, ee_b, ee_c};
                    default: eq2 <= {ee_a, ee_b, ee_c};
                endcase
                if (k != 2'd2) k <= k + 2'd1;
            end
            if (state == FINISH) begin
                area       <= area_sum;
                degenerate <= (area_sum == '0);
                backface   <= area_sum[AW-1];
            end
        end
    end
endmodule

// File: doc/tri_setup_ctrl.md
TRI_SETUP_CTRL -- requirements
Module: tri_setup_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 18, giving the width of the edge coefficients a, b and c (signed, two's complement).
REQ-002 The block SHALL have parameter AW, default 20, giving the width of the signed area sum.
REQ-003 The block SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to set up one triangle.
REQ-006 The block SHALL have ports x0, y0, x1, y1, x2, y2, input, 10 bits each: unsigned vertex coordinates, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: registered one-cycle pulse marking completed setup.
REQ-009 The block SHALL have ports eq0, eq1, eq2, output, 3*W bits each, packed {a,b,c}, for edge k.
REQ-010 The block SHALL have port area, output, AW bits: sign-extended c0+c1+c2 (twice the signed area).
REQ-011 The block SHALL have ports degenerate and backface, output, 1 bit each: area==0 and area<0.
REQ-012 The block SHALL have ports ee_trigger (output, 1), ee_x1, ee_y1, ee_x2, ee_y2 (output, 10 each), ee_valid (input, 1) and ee_a, ee_b, ee_c (input, W each): the edge-equation unit port.

Function
REQ-013 The block SHALL implement the states IDLE, ISSUE, SETTLE, WAIT and FINISH, with a 2-bit edge index k.
REQ-014 In IDLE, start=1 SHALL latch all six coordinates, clear k to 0 and go to ISSUE; start in any other state SHALL be ignored.
REQ-015 ee_trigger SHALL be combinational and equal (state==ISSUE && ee_valid), and SHALL never be high outside ISSUE.
REQ-016 ISSUE SHALL move to SETTLE on the edge where ee_trigger=1, and SHALL remain in ISSUE while ee_valid=0.
REQ-017 SETTLE SHALL last exactly one cycle and then go to WAIT, ignoring ee_valid.
REQ-018 In WAIT, ee_valid=1 SHALL capture {ee_a,ee_b,ee_c} into eq[k]; if k==2 the block SHALL go to FINISH, else it SHALL increment k and go to ISSUE.
REQ-019 ee_x1/ee_y1/ee_x2/ee_y2 SHALL be (v0,v1) for k=0, (v1,v2) for k=1 and (v2,v0) for k=2, driven from latched vertices and held stable from ISSUE through WAIT.
REQ-020 FINISH SHALL register area = sext(c0)+sext(c1)+sext(c2) to AW bits, register degenerate and backface from that sum, set done for the next cycle only, and return to IDLE.
REQ-021 done SHALL be high exactly one cycle (the first IDLE cycle), and start SHALL be accepted in that cycle.
REQ-022 eq0..eq2, area and the flags SHALL hold their values until overwritten by the next setup.
REQ-023 The sequencing SHALL be handshake-driven, not counted; with an edge unit that is idle on request (4-cycle unit), done SHALL rise on the 16th rising edge after the edge that sampled start.

Reset
REQ-024 reset=1 SHALL force IDLE, k=0, busy=0, done=0 and ee_trigger=0 asynchronously.
REQ-025 reset=1 SHALL clear eq0..eq2, area, degenerate, backface and the latched vertices to 0 asynchronously.
REQ-026 Reset asserted mid-setup SHALL abandon the triangle with no done pulse, and the next start after release SHALL begin cleanly at k=0.

Verification
REQ-027 Scenario 1: start with v0=(249,116), v1=(347,247), v2=(313,267) -> eq0=(-131,98,21251), eq1=(-20,-34,15338), eq2=(151,-64,-30175), area=6414, flags 0, done 16 edges after start.
REQ-028 Scenario 2: the same triangle with v1 and v2 swapped -> area=-6414, backface=1, degenerate=0.
REQ-029 Scenario 3: v0=(0,0), v1=(10,10), v2=(20,20) -> all c=0, area=0, degenerate=1, backface=0.
REQ-030 Scenario 4: hold ee_valid low for 3 extra cycles before edge 1 -> ee_trigger stays low while waiting, results match Scenario 1, done is delayed by 3 cycles.
REQ-031 Scenario 5: pulse start during busy, then assert start in the done cycle -> the mid-setup pulse is ignored and the second triangle starts immediately.
REQ-032 Scenario 6: assert reset during edge 1 WAIT -> busy and ee_trigger drop at once, no done pulse, outputs read 0, and a following start completes normally.
